// File: rtl/edge_pkg.sv
// Shared types and helpers for the frame-granular Sobel filter arbiter.
package edge_pkg;

  typedef logic [7:0] pixel_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } arb_state_t;

  // Number of pixels in one complete frame
  function automatic int frame_pix(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/fifo.sv
// Small synchronous first-word-fall-through FIFO; depth must be a power of 2, at least 2.
module fifo #(
  parameter int FIFO_DATA_WIDTH  = 8,
  parameter int FIFO_BUFFER_SIZE = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [FIFO_DATA_WIDTH-1:0] din,
  output logic                       full,
  input  logic                       rd_en,
  output logic [FIFO_DATA_WIDTH-1:0] dout,
  output logic                       empty
);

  localparam int AW = (FIFO_BUFFER_SIZE > 1) ? $clog2(FIFO_BUFFER_SIZE) : 1;

  logic [FIFO_DATA_WIDTH-1:0] mem [FIFO_BUFFER_SIZE];
  logic [AW-1:0]              wr_ptr;
  logic [AW-1:0]              rd_ptr;
  logic [AW:0]                count;
  logic                       do_wr;
  logic                       do_rd;

  assign full  = (count == (AW+1)'(FIFO_BUFFER_SIZE));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Storage array; contents need no reset because count gates visibility
  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      count <= count + 1'b1;
      else if (!do_wr && do_rd) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/edge_frame_arbiter.sv
// Shares one Sobel filter between two pixel sources a whole frame at a time,
// and returns each filtered frame to the source that owns it via a tag queue.
module edge_frame_arbiter
  import edge_pkg::*;
#(
  parameter int WIDTH     = 720,
  parameter int HEIGHT    = 540,
  parameter int TAG_DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  output logic         in0_rd_en,
  input  logic         in0_empty,
  input  pixel_t       in0_dout,
  output logic         in1_rd_en,
  input  logic         in1_empty,
  input  pixel_t       in1_dout,
  output logic         flt_wr_en,
  input  logic         flt_full,
  output pixel_t       flt_din,
  output logic         flt_rd_en,
  input  logic         flt_empty,
  input  pixel_t       flt_dout,
  output logic         out0_wr_en,
  input  logic         out0_full,
  output pixel_t       out0_din,
  output logic         out1_wr_en,
  input  logic         out1_full,
  output pixel_t       out1_din,
  output logic [15:0]  frames0,
  output logic [15:0]  frames1,
  output logic         busy
);

  localparam int FRAME_PIX = frame_pix(WIDTH, HEIGHT);
  localparam int CNT_W     = $clog2(FRAME_PIX);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIX - 1);

  arb_state_t       state;
  logic             grant_id;
  logic             ptr;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;

  logic grant_valid;
  logic grant_pick;
  logic in_move;
  logic out_move;
  logic tag_pop;
  logic tag_full;
  logic tag_empty;
  logic tag_head;

  // Tag queue remembers the owner of every frame granted but not yet fully returned
  fifo #(
    .FIFO_DATA_WIDTH (1),
    .FIFO_BUFFER_SIZE(TAG_DEPTH)
  ) tag_q (
    .clock(clock),
    .reset(reset),
    .wr_en(grant_valid),
    .din  (grant_pick),
    .full (tag_full),
    .rd_en(tag_pop),
    .dout (tag_head),
    .empty(tag_empty)
  );

  // Grant decision, zero-latency pixel steering on both sides, and busy flag
  always_comb begin
    grant_valid = 1'b0;
    grant_pick  = 1'b0;
    in_move     = 1'b0;
    out_move    = 1'b0;
    tag_pop     = 1'b0;
    in0_rd_en   = 1'b0;
    in1_rd_en   = 1'b0;
    flt_wr_en   = 1'b0;
    flt_din     = '0;
    flt_rd_en   = 1'b0;
    out0_wr_en  = 1'b0;
    out0_din    = '0;
    out1_wr_en  = 1'b0;
    out1_din    = '0;

    if (state == S_IDLE && !tag_full) begin
      if (!in0_empty && !in1_empty) begin
        grant_valid = 1'b1;
        grant_pick  = ptr;
      end else if (!in0_empty) begin
        grant_valid = 1'b1;
        grant_pick  = 1'b0;
      end else if (!in1_empty) begin
        grant_valid = 1'b1;
        grant_pick  = 1'b1;
      end
    end

    if (state == S_XFER && !flt_full) begin
      if (!grant_id && !in0_empty) begin
        in_move   = 1'b1;
        in0_rd_en = 1'b1;
        flt_wr_en = 1'b1;
        flt_din   = in0_dout;
      end else if (grant_id && !in1_empty) begin
        in_move   = 1'b1;
        in1_rd_en = 1'b1;
        flt_wr_en = 1'b1;
        flt_din   = in1_dout;
      end
    end

    if (!tag_empty && !flt_empty) begin
      if (!tag_head && !out0_full) begin
        out_move   = 1'b1;
        flt_rd_en  = 1'b1;
        out0_wr_en = 1'b1;
        out0_din   = flt_dout;
      end else if (tag_head && !out1_full) begin
        out_move   = 1'b1;
        flt_rd_en  = 1'b1;
        out1_wr_en = 1'b1;
        out1_din   = flt_dout;
      end
    end

    tag_pop = out_move && (out_cnt == LAST_PIX);
    busy    = (state == S_XFER) || !tag_empty;
  end

  // Ingress FSM, round-robin pointer, pixel counters and delivered-frame counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      grant_id <= 1'b0;
      ptr      <= 1'b0;
      in_cnt   <= '0;
      out_cnt  <= '0;
      frames0  <= '0;
      frames1  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            grant_id <= grant_pick;
            state    <= S_XFER;
          end
        end
        S_XFER: begin
          if (in_move) begin
            if (in_cnt == LAST_PIX) begin
              in_cnt <= '0;
              ptr    <= ~grant_id;
              state  <= S_IDLE;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      if (out_move) begin
        if (out_cnt == LAST_PIX) begin
          out_cnt <= '0;
          if (tag_head) frames1 <= frames1 + 16'd1;
          else          frames0 <= frames0 + 16'd1;
        end else begin
          out_cnt <= out_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_edge_frame_arbiter.sv
// Self-checking bench: FIFO/filter models around the arbiter, per-sink scoreboards,
// a table of arbitration scenarios and hand-written multi-cycle corner cases.
module tb_edge_frame_arbiter;
  import edge_pkg::*;

  localparam int W      = 4;
  localparam int H      = 3;
  localparam int FP     = 12;
  localparam int TD     = 2;
  localparam int FQ_CAP = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in0_rd_en, in1_rd_en, flt_wr_en, flt_rd_en, out0_wr_en, out1_wr_en, busy;
  logic        in0_empty, in1_empty, flt_full, flt_empty, out0_full, out1_full;
  pixel_t      in0_dout, in1_dout, flt_din, flt_dout, out0_din, out1_din;
  logic [15:0] frames0, frames1;

  pixel_t src0[$], src1[$], fq[$], exp0[$], exp1[$];
  bit     owner_q[$];
  int     wr_count, out0_count, out1_count;
  bit     force_full, flt_stall;
  int     compared, mismatched;

  logic   s_in0_rd, s_in1_rd, s_flt_wr, s_flt_rd, s_out0_wr, s_out1_wr;
  pixel_t s_flt_din;

  typedef struct {
    int       load0;
    int       load1;
    int       nfr;
    logic [3:0] order;
    int       exp_f0;
    int       exp_f1;
  } vec_t;

  vec_t vecs[6];

  always #5 clock = ~clock;

  edge_frame_arbiter #(.WIDTH(W), .HEIGHT(H), .TAG_DEPTH(TD)) dut (
    .clock(clock), .reset(reset),
    .in0_rd_en(in0_rd_en), .in0_empty(in0_empty), .in0_dout(in0_dout),
    .in1_rd_en(in1_rd_en), .in1_empty(in1_empty), .in1_dout(in1_dout),
    .flt_wr_en(flt_wr_en), .flt_full(flt_full), .flt_din(flt_din),
    .flt_rd_en(flt_rd_en), .flt_empty(flt_empty), .flt_dout(flt_dout),
    .out0_wr_en(out0_wr_en), .out0_full(out0_full), .out0_din(out0_din),
    .out1_wr_en(out1_wr_en), .out1_full(out1_full), .out1_din(out1_din),
    .frames0(frames0), .frames1(frames1), .busy(busy)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic refresh();
    in0_empty = (src0.size() == 0);
    in0_dout  = in0_empty ? 8'h00 : src0[0];
    in1_empty = (src1.size() == 0);
    in1_dout  = in1_empty ? 8'h00 : src1[0];
    flt_full  = force_full || (fq.size() >= FQ_CAP);
    flt_empty = flt_stall || (fq.size() == 0);
    flt_dout  = (fq.size() == 0) ? 8'h00 : fq[0];
  endtask

  // FIFO and filter models plus scoreboard: sample at negedge, commit just after posedge
  always begin
    @(negedge clock);
    s_in0_rd  = in0_rd_en;
    s_in1_rd  = in1_rd_en;
    s_flt_wr  = flt_wr_en;
    s_flt_rd  = flt_rd_en;
    s_out0_wr = out0_wr_en;
    s_out1_wr = out1_wr_en;
    s_flt_din = flt_din;
    if (s_in0_rd && s_in1_rd) check_output("both_src_read", 1, 0);
    if ((s_in0_rd || s_in1_rd) != s_flt_wr) check_output("rd_wr_pairing", s_flt_wr, s_in0_rd || s_in1_rd);
    if (s_flt_wr && s_in0_rd && src0.size() > 0) check_output("flt_din_src0", flt_din, src0[0]);
    if (s_flt_wr && s_in1_rd && src1.size() > 0) check_output("flt_din_src1", flt_din, src1[0]);
    if (!s_flt_wr) check_output("flt_din_idle_zero", flt_din, 0);
    if (s_out0_wr) begin
      if (exp0.size() == 0) check_output("out0_unexpected_write", 1, 0);
      else check_output("out0_pixel", out0_din, exp0.pop_front());
    end else check_output("out0_din_idle_zero", out0_din, 0);
    if (s_out1_wr) begin
      if (exp1.size() == 0) check_output("out1_unexpected_write", 1, 0);
      else check_output("out1_pixel", out1_din, exp1.pop_front());
    end else check_output("out1_din_idle_zero", out1_din, 0);
    if (s_out0_wr && s_out1_wr) check_output("both_sinks_written", 1, 0);
    if ((s_out0_wr || s_out1_wr) != s_flt_rd) check_output("flt_rd_pairing", s_flt_rd, s_out0_wr || s_out1_wr);
    @(posedge clock);
    #1;
    if (s_in0_rd && src0.size() > 0) void'(src0.pop_front());
    if (s_in1_rd && src1.size() > 0) void'(src1.pop_front());
    if (s_flt_rd && fq.size() > 0) void'(fq.pop_front());
    if (s_flt_wr) begin
      if (wr_count % FP == 0) owner_q.push_back(s_in1_rd);
      wr_count++;
      fq.push_back(s_flt_din);
    end
    if (s_out0_wr) out0_count++;
    if (s_out1_wr) out1_count++;
    refresh();
  end

  task automatic apply_reset();
    @(posedge clock);
    #2;
    reset      = 1'b1;
    force_full = 1'b0;
    flt_stall  = 1'b0;
    out0_full  = 1'b0;
    out1_full  = 1'b0;
    src0.delete(); src1.delete(); fq.delete(); exp0.delete(); exp1.delete(); owner_q.delete();
    wr_count = 0; out0_count = 0; out1_count = 0;
    refresh();
    repeat (2) @(posedge clock);
  endtask

  task automatic release_reset();
    @(posedge clock);
    #2;
    reset = 1'b0;
  endtask

  task automatic load_frames(input int src, input int n);
    pixel_t v;
    for (int i = 0; i < n * FP; i++) begin
      v = pixel_t'($urandom_range(0, 255));
      if (src == 0) begin src0.push_back(v); exp0.push_back(v); end
      else          begin src1.push_back(v); exp1.push_back(v); end
    end
    refresh();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clock);
      #2;
      if (src0.size() == 0 && src1.size() == 0 && fq.size() == 0 &&
          exp0.size() == 0 && exp1.size() == 0 && busy == 1'b0) break;
    end
    check_output({name, "_drained"}, i < budget, 1);
  endtask

  task automatic apply_stimulus(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    apply_reset();
    load_frames(0, v.load0);
    load_frames(1, v.load1);
    release_reset();
    wait_idle(tag, 400);
    check_output({tag, "_frames0"}, frames0, v.exp_f0);
    check_output({tag, "_frames1"}, frames1, v.exp_f1);
    check_output({tag, "_nframes"}, owner_q.size(), v.nfr);
    for (int j = 0; j < v.nfr && j < owner_q.size(); j++)
      check_output($sformatf("%s_owner%0d", tag, j), owner_q[j], v.order[j]);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int ok;
    int moves;
    compared   = 0;
    mismatched = 0;
    out0_full  = 1'b0;
    out1_full  = 1'b0;
    refresh();

    vecs[0] = '{1, 0, 1, 4'b0000, 1, 0};
    vecs[1] = '{0, 1, 1, 4'b0001, 0, 1};
    vecs[2] = '{2, 1, 3, 4'b0010, 2, 1};
    vecs[3] = '{1, 2, 3, 4'b0110, 1, 2};
    vecs[4] = '{2, 0, 2, 4'b0000, 2, 0};
    vecs[5] = '{1, 1, 2, 4'b0010, 1, 1};

    // Reset state
    apply_reset();
    load_frames(0, 1);
    @(negedge clock);
    check_output("reset_enables", {in0_rd_en, in1_rd_en, flt_wr_en, flt_rd_en, out0_wr_en, out1_wr_en}, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_frames", {frames0, frames1}, 0);

    // Arbitration scenarios
    for (int k = 0; k < 6; k++) apply_stimulus(k, vecs[k]);

    // Filter input back-pressure after pixel 5
    apply_reset();
    load_frames(0, 1);
    release_reset();
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #2;
      if (wr_count == 6) begin ok = 1; break; end
    end
    check_output("t3_reach6", ok, 1);
    force_full = 1'b1;
    refresh();
    moves = 0;
    repeat (5) begin
      @(negedge clock);
      if (in0_rd_en || flt_wr_en) moves++;
    end
    check_output("t3_stall_moves", moves, 0);
    check_output("t3_in_cnt_hold", dut.in_cnt, 6);
    @(posedge clock); #2;
    force_full = 1'b0;
    refresh();
    wait_idle("t3", 200);
    check_output("t3_frames0", frames0, 1);
    check_output("t3_wr_count", wr_count, 12);
    check_output("t3_out0_count", out0_count, 12);

    // Tag queue full: only two grants until the first frame returns
    apply_reset();
    out0_full = 1'b1;
    out1_full = 1'b1;
    flt_stall = 1'b1;
    refresh();
    load_frames(0, 3);
    release_reset();
    repeat (80) @(posedge clock);
    #2;
    check_output("t4_two_frames_in", wr_count, 24);
    check_output("t4_third_held", src0.size(), 12);
    check_output("t4_busy", busy, 1);
    out0_full = 1'b0;
    flt_stall = 1'b0;
    refresh();
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #2;
      if (out0_count == 12) begin ok = 1; break; end
    end
    check_output("t4_first_return", ok, 1);
    check_output("t4_no_early_grant", wr_count, 24);
    @(negedge clock);
    check_output("t4_grant_cycle", in0_rd_en, 0);
    @(negedge clock);
    check_output("t4_third_xfer", in0_rd_en, 1);
    wait_idle("t4", 300);
    check_output("t4_frames0", frames0, 3);

    // Sink 1 blocked at head of tag queue while in0 ingress continues
    apply_reset();
    out1_full = 1'b1;
    load_frames(1, 1);
    release_reset();
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #2;
      if (wr_count == 12) begin ok = 1; break; end
    end
    check_output("t5_in1_frame_in", ok, 1);
    load_frames(0, 1);
    moves = 0;
    repeat (20) begin
      @(negedge clock);
      if (flt_rd_en) moves++;
    end
    check_output("t5_flt_rd_blocked", moves, 0);
    @(posedge clock); #2;
    check_output("t5_in0_ingress", wr_count, 24);
    check_output("t5_out0_held", out0_count, 0);
    out1_full = 1'b0;
    refresh();
    wait_idle("t5", 200);
    check_output("t5_frames1", frames1, 1);
    check_output("t5_frames0", frames0, 1);

    // Mid-frame reset discards in-flight work
    apply_reset();
    load_frames(0, 1);
    release_reset();
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #2;
      if (wr_count == 7) begin ok = 1; break; end
    end
    check_output("t6_reach7", ok, 1);
    reset = 1'b1;
    @(negedge clock);
    check_output("t6_enables", {in0_rd_en, in1_rd_en, flt_wr_en, flt_rd_en, out0_wr_en, out1_wr_en}, 0);
    check_output("t6_in_cnt", dut.in_cnt, 0);
    check_output("t6_out_cnt", dut.out_cnt, 0);
    check_output("t6_ptr", dut.ptr, 0);
    check_output("t6_frames", {frames0, frames1}, 0);
    check_output("t6_busy", busy, 0);
    apply_reset();
    load_frames(0, 1);
    release_reset();
    wait_idle("t6_recover", 200);
    check_output("t6_recover_frames0", frames0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
